// File: rtl/axilite_mmio_slave.sv
// AXI4-Lite MMIO responder: ID/scratch/LED/interrupt control-status registers
// plus a free-running 64-bit cycle counter with a latched high half.
module axilite_mmio_slave #(
    parameter int          ADDR_WIDTH = 32,
    parameter logic [31:0] ID_VALUE   = 32'h50415244
) (
    input  logic                  uncoreclk,
    input  logic                  uncore_rstn,
    input  logic [ADDR_WIDTH-1:0] s_axilite_awaddr,
    input  logic                  s_axilite_awvalid,
    output logic                  s_axilite_awready,
    input  logic [31:0]           s_axilite_wdata,
    input  logic [3:0]            s_axilite_wstrb,
    input  logic                  s_axilite_wvalid,
    output logic                  s_axilite_wready,
    output logic [1:0]            s_axilite_bresp,
    output logic                  s_axilite_bvalid,
    input  logic                  s_axilite_bready,
    input  logic [ADDR_WIDTH-1:0] s_axilite_araddr,
    input  logic                  s_axilite_arvalid,
    output logic                  s_axilite_arready,
    output logic [31:0]           s_axilite_rdata,
    output logic [1:0]            s_axilite_rresp,
    output logic                  s_axilite_rvalid,
    input  logic                  s_axilite_rready,
    input  logic                  intr0,
    input  logic                  intr1,
    output logic [7:0]            led,
    output logic                  irq
);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [5:0] OFF_ID      = 6'd0;
    localparam logic [5:0] OFF_SCRATCH = 6'd1;
    localparam logic [5:0] OFF_LED     = 6'd2;
    localparam logic [5:0] OFF_STATUS  = 6'd3;
    localparam logic [5:0] OFF_ENABLE  = 6'd4;
    localparam logic [5:0] OFF_CYC_LO  = 6'd5;
    localparam logic [5:0] OFF_CYC_HI  = 6'd6;

    // one-entry AW / W holding buffers
    logic        aw_full, w_full;
    logic [5:0]  aw_off;
    logic [31:0] w_data;
    logic [3:0]  w_strb;

    // register file
    logic [31:0] scratch;
    logic [1:0]  intr_status, intr_enable, intr_prev;
    logic [63:0] cycle;
    logic [31:0] cycle_hi_shadow;

    logic        aw_hs, w_hs, ar_hs, commit, wr_err, rd_err;
    logic [5:0]  wr_off, rd_off;
    logic [31:0] wr_data, rd_value;
    logic [3:0]  wr_strb;
    logic [1:0]  intr_rise, intr_clr;

    // only addr[7:2] is decoded; the rest is intentionally dropped
    logic unused_addr;
    assign unused_addr = ^{s_axilite_awaddr[ADDR_WIDTH-1:8], s_axilite_awaddr[1:0],
                           s_axilite_araddr[ADDR_WIDTH-1:8], s_axilite_araddr[1:0]};

    assign s_axilite_awready = !aw_full && !s_axilite_bvalid;
    assign s_axilite_wready  = !w_full && !s_axilite_bvalid;
    assign s_axilite_arready = !s_axilite_rvalid;

    assign aw_hs = s_axilite_awvalid && s_axilite_awready;
    assign w_hs  = s_axilite_wvalid && s_axilite_wready;
    assign ar_hs = s_axilite_arvalid && s_axilite_arready;

    // a handshake this cycle counts as a full buffer so AW+W in cycle N gives B in N+1
    assign wr_off  = aw_full ? aw_off : s_axilite_awaddr[7:2];
    assign wr_data = w_full ? w_data : s_axilite_wdata;
    assign wr_strb = w_full ? w_strb : s_axilite_wstrb;
    assign commit  = (aw_full || aw_hs) && (w_full || w_hs);
    assign wr_err  = wr_off > OFF_CYC_HI;
    assign rd_off  = s_axilite_araddr[7:2];

    assign intr_rise = {intr1, intr0} & ~intr_prev;
    assign intr_clr  = (commit && wr_off == OFF_STATUS && wr_strb[0]) ? wr_data[1:0] : 2'b00;

    function automatic logic [31:0] apply_strb(input logic [31:0] old_v, input logic [31:0] new_v,
                                               input logic [3:0] strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++)
            res[8*i +: 8] = strb[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        return res;
    endfunction

    // read mux: decode the AR offset against current register state
    always_comb begin
        rd_value = 32'h0;
        rd_err   = 1'b0;
        case (rd_off)
            OFF_ID:      rd_value = ID_VALUE;
            OFF_SCRATCH: rd_value = scratch;
            OFF_LED:     rd_value = {24'h0, led};
            OFF_STATUS:  rd_value = {30'h0, intr_status};
            OFF_ENABLE:  rd_value = {30'h0, intr_enable};
            OFF_CYC_LO:  rd_value = cycle[31:0];
            OFF_CYC_HI:  rd_value = cycle_hi_shadow;
            default:     rd_err   = 1'b1;
        endcase
    end

    // write channel: buffer AW/W independently, commit when both present, hold B until bready
    always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
        if (!uncore_rstn) begin
            aw_full          <= 1'b0;
            w_full           <= 1'b0;
            aw_off           <= 6'h0;
            w_data           <= 32'h0;
            w_strb           <= 4'h0;
            s_axilite_bvalid <= 1'b0;
            s_axilite_bresp  <= RESP_OKAY;
        end else begin
            if (commit) begin
                aw_full <= 1'b0;
                w_full  <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_full <= 1'b1;
                    aw_off  <= s_axilite_awaddr[7:2];
                end
                if (w_hs) begin
                    w_full <= 1'b1;
                    w_data <= s_axilite_wdata;
                    w_strb <= s_axilite_wstrb;
                end
            end
            if (commit) begin
                s_axilite_bvalid <= 1'b1;
                s_axilite_bresp  <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else if (s_axilite_bvalid && s_axilite_bready) begin
                s_axilite_bvalid <= 1'b0;
            end
        end
    end

    // register updates; interrupt rising edges win over a same-cycle W1C
    always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
        if (!uncore_rstn) begin
            scratch     <= 32'h0;
            led         <= 8'h0;
            intr_enable <= 2'b00;
            intr_status <= 2'b00;
            intr_prev   <= 2'b00;
            irq         <= 1'b0;
        end else begin
            if (commit) begin
                case (wr_off)
                    OFF_SCRATCH: scratch <= apply_strb(scratch, wr_data, wr_strb);
                    OFF_LED:     if (wr_strb[0]) led <= wr_data[7:0];
                    OFF_ENABLE:  if (wr_strb[0]) intr_enable <= wr_data[1:0];
                    default:     ;
                endcase
            end
            intr_status <= (intr_status & ~intr_clr) | intr_rise;
            intr_prev   <= {intr1, intr0};
            irq         <= |(intr_status & intr_enable);
        end
    end

    // free-running cycle counter; a CYCLE_LO read latches the high half for a coherent pair
    always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
        if (!uncore_rstn) begin
            cycle           <= 64'h0;
            cycle_hi_shadow <= 32'h0;
        end else begin
            cycle <= cycle + 64'd1;
            if (ar_hs && rd_off == OFF_CYC_LO)
                cycle_hi_shadow <= cycle[63:32];
        end
    end

    // read channel: register data on AR handshake, hold until rready
    always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
        if (!uncore_rstn) begin
            s_axilite_rvalid <= 1'b0;
            s_axilite_rdata  <= 32'h0;
            s_axilite_rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            s_axilite_rvalid <= 1'b1;
            s_axilite_rdata  <= rd_value;
            s_axilite_rresp  <= rd_err ? RESP_SLVERR : RESP_OKAY;
        end else if (s_axilite_rvalid && s_axilite_rready) begin
            s_axilite_rvalid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_axilite_mmio_slave.sv
// Bench for axilite_mmio_slave: vector table through a response scoreboard,
// plus hand sequences for W-before-AW, read back-pressure, interrupts and reset.
module tb_axilite_mmio_slave;
    logic        uncoreclk = 1'b0;
    logic        uncore_rstn = 1'b0;
    logic [31:0] s_axilite_awaddr = '0;
    logic        s_axilite_awvalid = 1'b0;
    logic        s_axilite_awready;
    logic [31:0] s_axilite_wdata = '0;
    logic [3:0]  s_axilite_wstrb = '0;
    logic        s_axilite_wvalid = 1'b0;
    logic        s_axilite_wready;
    logic [1:0]  s_axilite_bresp;
    logic        s_axilite_bvalid;
    logic        s_axilite_bready = 1'b0;
    logic [31:0] s_axilite_araddr = '0;
    logic        s_axilite_arvalid = 1'b0;
    logic        s_axilite_arready;
    logic [31:0] s_axilite_rdata;
    logic [1:0]  s_axilite_rresp;
    logic        s_axilite_rvalid;
    logic        s_axilite_rready = 1'b0;
    logic        intr0 = 1'b0;
    logic        intr1 = 1'b0;
    logic [7:0]  led;
    logic        irq;

    localparam logic [31:0] ID = 32'h50415244;

    axilite_mmio_slave #(.ADDR_WIDTH(32), .ID_VALUE(ID)) dut (
        .uncoreclk(uncoreclk), .uncore_rstn(uncore_rstn),
        .s_axilite_awaddr(s_axilite_awaddr), .s_axilite_awvalid(s_axilite_awvalid),
        .s_axilite_awready(s_axilite_awready), .s_axilite_wdata(s_axilite_wdata),
        .s_axilite_wstrb(s_axilite_wstrb), .s_axilite_wvalid(s_axilite_wvalid),
        .s_axilite_wready(s_axilite_wready), .s_axilite_bresp(s_axilite_bresp),
        .s_axilite_bvalid(s_axilite_bvalid), .s_axilite_bready(s_axilite_bready),
        .s_axilite_araddr(s_axilite_araddr), .s_axilite_arvalid(s_axilite_arvalid),
        .s_axilite_arready(s_axilite_arready), .s_axilite_rdata(s_axilite_rdata),
        .s_axilite_rresp(s_axilite_rresp), .s_axilite_rvalid(s_axilite_rvalid),
        .s_axilite_rready(s_axilite_rready), .intr0(intr0), .intr1(intr1),
        .led(led), .irq(irq)
    );

    always #5 uncoreclk = ~uncoreclk;

    // reference cycle count: cycles elapsed since reset release
    logic [63:0] cyc_model;
    always @(posedge uncoreclk or negedge uncore_rstn)
        if (!uncore_rstn) cyc_model <= 64'h0;
        else              cyc_model <= cyc_model + 64'd1;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        bit          is_wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t        tbl[$];
    logic [33:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic collect_b(output logic [1:0] resp, output bit ok);
        int n = 0;
        while (!s_axilite_bvalid && n < 20) begin @(negedge uncoreclk); n++; end
        ok   = s_axilite_bvalid;
        resp = s_axilite_bresp;
        s_axilite_bready = 1'b1;
        @(negedge uncoreclk);
        s_axilite_bready = 1'b0;
    endtask

    // AW and W presented together; first_b is bvalid one cycle after the handshake
    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp, output bit first_b, output bit ok);
        bit aw_hs, w_hs;
        @(negedge uncoreclk);
        s_axilite_awaddr = addr; s_axilite_wdata = data; s_axilite_wstrb = strb;
        s_axilite_awvalid = 1'b1; s_axilite_wvalid = 1'b1;
        for (int i = 0; i < 20 && (s_axilite_awvalid || s_axilite_wvalid); i++) begin
            aw_hs = s_axilite_awready; w_hs = s_axilite_wready;
            @(negedge uncoreclk);
            if (aw_hs) s_axilite_awvalid = 1'b0;
            if (w_hs)  s_axilite_wvalid  = 1'b0;
        end
        ok = !(s_axilite_awvalid || s_axilite_wvalid);
        s_axilite_awvalid = 1'b0; s_axilite_wvalid = 1'b0;
        first_b = s_axilite_bvalid;
        resp = 2'bxx;
        if (ok) collect_b(resp, ok);
    endtask

    // cyc_at is the reference count in the AR handshake cycle
    task automatic do_read(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp,
                           output logic [63:0] cyc_at, output bit ok);
        int n = 0;
        @(negedge uncoreclk);
        s_axilite_araddr = addr; s_axilite_arvalid = 1'b1;
        cyc_at = cyc_model;
        while (!s_axilite_arready && n < 20) begin @(negedge uncoreclk); n++; cyc_at = cyc_model; end
        @(negedge uncoreclk);
        s_axilite_arvalid = 1'b0;
        n = 0;
        while (!s_axilite_rvalid && n < 20) begin @(negedge uncoreclk); n++; end
        ok = s_axilite_rvalid;
        data = s_axilite_rdata; resp = s_axilite_rresp;
        s_axilite_rready = 1'b1;
        @(negedge uncoreclk);
        s_axilite_rready = 1'b0;
    endtask

    task automatic sb_read(input string name, input logic [31:0] addr,
                           input logic [31:0] exp_d, input logic [1:0] exp_r);
        logic [31:0] d; logic [1:0] r; logic [63:0] c; bit ok;
        logic [33:0] e;
        exp_q.push_back({exp_r, exp_d});
        do_read(addr, d, r, c, ok);
        e = exp_q.pop_front();
        check({name, "_done"}, ok, 1);
        check({name, "_rdata"}, d, e[31:0]);
        check({name, "_rresp"}, r, e[33:32]);
    endtask

    logic [31:0] d, lo1, lo2, hi1;
    logic [1:0]  r;
    logic [63:0] c1, c2;
    bit          ok, fb;
    logic [33:0] e;

    initial begin
        tbl.push_back('{1'b0, 32'h18,  32'h0,        4'h0, 32'h0,        2'd0});
        tbl.push_back('{1'b1, 32'h04,  32'hDEADBEEF, 4'hF, 32'h0,        2'd0});
        tbl.push_back('{1'b0, 32'h04,  32'h0,        4'h0, 32'hDEADBEEF, 2'd0});
        tbl.push_back('{1'b0, 32'h00,  32'h0,        4'h0, ID,           2'd0});
        tbl.push_back('{1'b1, 32'h04,  32'h00001200, 4'h2, 32'h0,        2'd0});
        tbl.push_back('{1'b0, 32'h04,  32'h0,        4'h0, 32'hDEAD12EF, 2'd0});
        tbl.push_back('{1'b1, 32'h20,  32'h12345678, 4'hF, 32'h0,        2'd2});
        tbl.push_back('{1'b0, 32'h20,  32'h0,        4'h0, 32'h0,        2'd2});
        tbl.push_back('{1'b0, 32'h04,  32'h0,        4'h0, 32'hDEAD12EF, 2'd0});
        tbl.push_back('{1'b1, 32'h00,  32'hFFFFFFFF, 4'hF, 32'h0,        2'd0});
        tbl.push_back('{1'b0, 32'h00,  32'h0,        4'h0, ID,           2'd0});
        tbl.push_back('{1'b1, 32'h1C,  32'h1,        4'hF, 32'h0,        2'd2});
        tbl.push_back('{1'b0, 32'h1C,  32'h0,        4'h0, 32'h0,        2'd2});
        tbl.push_back('{1'b0, 32'h107, 32'h0,        4'h0, 32'hDEAD12EF, 2'd0});
        tbl.push_back('{1'b1, 32'h10,  32'hFFFFFFFF, 4'hE, 32'h0,        2'd0});
        tbl.push_back('{1'b0, 32'h10,  32'h0,        4'h0, 32'h0,        2'd0});
        tbl.push_back('{1'b0, 32'h0C,  32'h0,        4'h0, 32'h0,        2'd0});

        // reset state
        repeat (3) @(negedge uncoreclk);
        check("rst_bvalid", s_axilite_bvalid, 0);
        check("rst_rvalid", s_axilite_rvalid, 0);
        check("rst_led", led, 0);
        check("rst_irq", irq, 0);
        check("rst_rdata", s_axilite_rdata, 0);
        uncore_rstn = 1'b1;
        @(negedge uncoreclk);
        check("rst_readies", {s_axilite_awready, s_axilite_wready, s_axilite_arready}, 3'b111);

        // vector table through the scoreboard
        foreach (tbl[i]) begin
            if (tbl[i].is_wr) begin
                exp_q.push_back({tbl[i].exp_resp, 32'h0});
                do_write(tbl[i].addr, tbl[i].data, tbl[i].strb, r, fb, ok);
                e = exp_q.pop_front();
                check($sformatf("vec%0d_wr_done", i), ok, 1);
                check($sformatf("vec%0d_b_latency", i), fb, 1);
                check($sformatf("vec%0d_bresp", i), r, e[33:32]);
            end else begin
                sb_read($sformatf("vec%0d", i), tbl[i].addr, tbl[i].exp_data, tbl[i].exp_resp);
            end
        end

        // W three cycles ahead of AW, LED write with only byte 0 strobed
        @(negedge uncoreclk);
        s_axilite_wdata = 32'h1A5; s_axilite_wstrb = 4'h1; s_axilite_wvalid = 1'b1;
        check("wfirst_wready", s_axilite_wready, 1);
        @(negedge uncoreclk);
        s_axilite_wvalid = 1'b0;
        check("wfirst_wbuf_full", s_axilite_wready, 0);
        check("wfirst_no_b0", s_axilite_bvalid, 0);
        @(negedge uncoreclk);
        check("wfirst_no_b1", s_axilite_bvalid, 0);
        @(negedge uncoreclk);
        check("wfirst_no_b2", s_axilite_bvalid, 0);
        s_axilite_awaddr = 32'h08; s_axilite_awvalid = 1'b1;
        check("wfirst_awready", s_axilite_awready, 1);
        @(negedge uncoreclk);
        s_axilite_awvalid = 1'b0;
        check("wfirst_b_latency", s_axilite_bvalid, 1);
        collect_b(r, ok);
        check("wfirst_bresp", {ok, r}, 3'b100);
        check("wfirst_led", led, 8'hA5);
        check("wfirst_single_b", s_axilite_bvalid, 0);
        sb_read("led_rd", 32'h08, 32'h000000A5, 2'd0);

        // ID read held off by rready low for 5 cycles
        @(negedge uncoreclk);
        s_axilite_araddr = 32'h00; s_axilite_arvalid = 1'b1;
        @(negedge uncoreclk);
        s_axilite_arvalid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check($sformatf("hold%0d", k), {s_axilite_rvalid, s_axilite_arready, s_axilite_rdata},
                  {1'b1, 1'b0, ID});
            @(negedge uncoreclk);
        end
        s_axilite_rready = 1'b1;
        @(negedge uncoreclk);
        s_axilite_rready = 1'b0;
        check("hold_release", {s_axilite_rvalid, s_axilite_arready}, 2'b01);

        // interrupts: enable bit 1, pulse intr1
        do_write(32'h10, 32'h2, 4'h1, r, fb, ok);
        check("en_wr", {ok, r}, 3'b100);
        @(negedge uncoreclk); intr1 = 1'b1;
        @(negedge uncoreclk); intr1 = 1'b0;
        repeat (2) @(negedge uncoreclk);
        check("irq_set", irq, 1);
        sb_read("status_set", 32'h0C, 32'h2, 2'd0);

        // W1C of bit 1 in the same cycle as a new intr1 rising edge: set wins
        @(negedge uncoreclk);
        s_axilite_awaddr = 32'h0C; s_axilite_wdata = 32'h2; s_axilite_wstrb = 4'h1;
        s_axilite_awvalid = 1'b1; s_axilite_wvalid = 1'b1; intr1 = 1'b1;
        check("setwin_ready", {s_axilite_awready, s_axilite_wready}, 2'b11);
        @(negedge uncoreclk);
        s_axilite_awvalid = 1'b0; s_axilite_wvalid = 1'b0;
        collect_b(r, ok);
        intr1 = 1'b0;
        check("setwin_b", {ok, r}, 3'b100);
        sb_read("status_setwin", 32'h0C, 32'h2, 2'd0);
        check("irq_still", irq, 1);
        do_write(32'h0C, 32'h2, 4'h1, r, fb, ok);
        check("w1c_wr", {ok, r}, 3'b100);
        sb_read("status_clr", 32'h0C, 32'h0, 2'd0);
        repeat (2) @(negedge uncoreclk);
        check("irq_clr", irq, 0);

        // cycle counter: LO read latches HI; exact value of the AR handshake cycle
        do_read(32'h14, lo1, r, c1, ok);
        check("cyc_lo1", {ok, lo1}, {1'b1, c1[31:0]});
        do_read(32'h18, hi1, r, c2, ok);
        check("cyc_hi1", {ok, hi1}, {1'b1, c1[63:32]});
        do_read(32'h14, lo2, r, c2, ok);
        check("cyc_lo2", {ok, lo2}, {1'b1, c2[31:0]});
        check("cyc_monotonic", lo2 > lo1, 1);

        // reset while a write response is pending
        @(negedge uncoreclk);
        s_axilite_awaddr = 32'h04; s_axilite_wdata = 32'h11111111; s_axilite_wstrb = 4'hF;
        s_axilite_awvalid = 1'b1; s_axilite_wvalid = 1'b1;
        @(negedge uncoreclk);
        s_axilite_awvalid = 1'b0; s_axilite_wvalid = 1'b0;
        check("pend_bvalid", s_axilite_bvalid, 1);
        #2 uncore_rstn = 1'b0;
        #1;
        check("arst_bvalid", s_axilite_bvalid, 0);
        check("arst_led", led, 0);
        @(negedge uncoreclk);
        uncore_rstn = 1'b1;
        @(negedge uncoreclk);
        check("post_rst_bvalid", s_axilite_bvalid, 0);
        do_read(32'h14, lo1, r, c1, ok);
        check("post_rst_cyc", {ok, lo1}, {1'b1, c1[31:0]});
        check("post_rst_cyc_small", lo1 < 32'd8, 1);
        sb_read("post_rst_scratch", 32'h04, 32'h0, 2'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
